wait_state_memory: RTL and testbench
====================================

WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

Interface
REQ-001 Parameter ADDR_W, default 6, block-address width; depth = 2**ADDR_W blocks.
REQ-002 Parameter WORD_W, default 8, bits per word.
REQ-003 Parameter WORDS_PER_BLOCK, default 4, words per block; block width BW = WORD_W*WORDS_PER_BLOCK.
REQ-004 Parameter LATENCY, default 3, access latency in cycles; legal range 1..15.
REQ-005 Port clk  in  1  single clock, all state on rising edge.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port u_request  in  1  access request, sampled on rising edge.
REQ-008 Port u_we  in  1  1 = write, 0 = read; qualified by u_request.
REQ-009 Port u_be  in  WORDS_PER_BLOCK  per-word write enable; bit j covers word j, bits [WORD_W*j +: WORD_W].
REQ-010 Port u_addr  in  ADDR_W  block address.
REQ-011 Port u_din  in  BW  write block.
REQ-012 Port u_busy  out  1  high while an access is in flight; requests are ignored.
REQ-013 Port u_ready  out  1  one-cycle completion pulse.
REQ-014 Port u_dout  out  BW  registered read block.

Function
REQ-015 FSM states are IDLE, WAIT and DONE; u_busy SHALL be high in WAIT and DONE.
REQ-016 In IDLE, u_request=1 at an edge SHALL accept the access: latch u_we, u_be, u_addr and u_din; load the down-counter with LATENCY-1; go to WAIT, or go directly to DONE when LATENCY=1.
REQ-017 WAIT SHALL decrement the counter each edge and go to DONE on the edge where the counter equals 1.
REQ-018 u_ready SHALL be high exactly in DONE, for one cycle; DONE returns to IDLE on the next edge.
REQ-019 Timing: request accepted at edge E0 SHALL give u_ready high after edge E0+LATENCY-1 and low after edge E0+LATENCY; with LATENCY=1, u_ready is high the cycle after acceptance.
REQ-020 A write SHALL update only the words whose latched u_be bit is 1, on the edge entering DONE; u_be=0 completes with no change.
REQ-021 A read SHALL load u_dout with mem[latched addr] on the edge entering DONE.
REQ-022 u_dout SHALL hold its value until the next read completes; writes never change u_dout.
REQ-023 u_request in WAIT or DONE SHALL be ignored, with no queuing and no side effect; the requester re-issues it after u_busy falls.
REQ-024 Input changes after acceptance SHALL NOT affect the in-flight access.
REQ-025 Throughput SHALL be one access per LATENCY+1 cycles when u_request is held high continuously.
REQ-026 The counter width SHALL be 4 bits; wrap-around is not permitted.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, u_busy=0, u_ready=0, u_dout=0 and counter=0.
REQ-028 Reset during WAIT SHALL abort the access: a pending write is not committed, and memory contents are retained.
REQ-029 The first request SHALL be accepted on the first rising edge after rst_n rises.

Configuration
REQ-030 Macro WAIT_STATE_MEMORY_INIT_PATTERN_EN, when defined, SHALL initialise word j of block i to (WORDS_PER_BLOCK*i+j) mod 2**WORD_W at time zero.
REQ-031 When the macro is undefined, every memory word SHALL initialise to 0.
REQ-032 Memory initialisation SHALL occur only at time zero; rst_n never reinitialises memory.

Verification (defaults, macro defined)
REQ-033 Read addr 5 at E0 -> u_ready high after E0+2 only, u_dout=0x17161514, u_busy high after E0 through E0+2.
REQ-034 Write addr 2, u_be=4'b0101, u_din=0xAABBCCDD, then read addr 2 -> u_dout=0x0BBB09DD.
REQ-035 u_request held high reading addr 0 then addr 1 -> second u_ready pulse exactly 4 cycles after the first; the request during busy is ignored.
REQ-036 rst_n low in WAIT of write addr 3 with u_din=0xFFFFFFFF and u_be=4'hF -> outputs zero, and a later read of addr 3 returns 0x0F0E0D0C.
REQ-037 LATENCY=1 build, read addr 63 -> u_ready the cycle after acceptance, u_dout=0xFFFEFDFC; macro undefined -> u_dout=0.

Source files
------------

// File: rtl/wait_state_memory.sv
// wait_state_memory: block-organised memory with a fixed access latency.
// An access is accepted in IDLE, waits LATENCY-1 cycles in WAIT, and
// completes in DONE with a one-cycle u_ready pulse. Requests arriving
// while busy are dropped, and the requester must re-issue them.
// Optional macro WAIT_STATE_MEMORY_INIT_PATTERN_EN: when it is defined,
// word j of block i powers up as (WORDS_PER_BLOCK*i+j) mod 2**WORD_W.
// When it is undefined, every word powers up as zero.
module wait_state_memory #(
    parameter int ADDR_W          = 6,
    parameter int WORD_W          = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int LATENCY         = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              u_request,
    input  logic                              u_we,
    input  logic [WORDS_PER_BLOCK-1:0]        u_be,
    input  logic [ADDR_W-1:0]                 u_addr,
    input  logic [WORD_W*WORDS_PER_BLOCK-1:0] u_din,
    output logic                              u_busy,
    output logic                              u_ready,
    output logic [WORD_W*WORDS_PER_BLOCK-1:0] u_dout
);

    localparam int         BW       = WORD_W * WORDS_PER_BLOCK;
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
`ifdef WAIT_STATE_MEMORY_INIT_PATTERN_EN
    localparam bit INIT_PATTERN = 1'b1;
`else
    localparam bit INIT_PATTERN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    // Power-up contents of block i (only applied at time zero, never by reset).
    function automatic logic [BW-1:0] init_blk(input int i);
        logic [BW-1:0] v;
        v = '0;
        if (INIT_PATTERN)
            for (int j = 0; j < WORDS_PER_BLOCK; j++)
                v[WORD_W*j +: WORD_W] = WORD_W'(WORDS_PER_BLOCK * i + j);
        return v;
    endfunction

    state_t                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic                         busy_q, busy_d;
    logic                         ready_q, ready_d;
    logic [BW-1:0]                dout_q, dout_d;
    logic                         we_q, we_d;
    logic [WORDS_PER_BLOCK-1:0]   be_q, be_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [BW-1:0]                din_q, din_d;

    // Effective access fields: live inputs on the accepting edge (needed when
    // LATENCY=1 commits on that same edge), latched copies afterwards.
    logic                         acc_we;
    logic [WORDS_PER_BLOCK-1:0]   acc_be;
    logic [ADDR_W-1:0]            acc_addr;
    logic [BW-1:0]                acc_din;
    logic                         commit;
    logic                         wr_en;
    logic [BW-1:0]                rd_blk [DEPTH];

    // Next-state, counter, latch and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        din_d    = din_q;
        commit   = 1'b0;
        acc_we   = (state_q == S_IDLE) ? u_we   : we_q;
        acc_be   = (state_q == S_IDLE) ? u_be   : be_q;
        acc_addr = (state_q == S_IDLE) ? u_addr : addr_q;
        acc_din  = (state_q == S_IDLE) ? u_din  : din_q;
        case (state_q)
            S_IDLE: begin
                if (u_request) begin
                    we_d   = u_we;
                    be_d   = u_be;
                    addr_d = u_addr;
                    din_d  = u_din;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Gating with rst_n keeps a clock edge during reset from committing.
        wr_en   = commit & acc_we & rst_n;
        dout_d  = (commit && !acc_we) ? rd_blk[acc_addr] : dout_q;
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_DONE);
    end

    // Control FSM and registered outputs; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign u_busy  = busy_q;
    assign u_ready = ready_q;
    assign u_dout  = dout_q;

    // Storage: one register per block, with byte-lane style word enables.
    for (genvar i = 0; i < DEPTH; i++) begin : g_blk
        logic [BW-1:0] blk_q = init_blk(i);
        logic [BW-1:0] blk_d;

        // Merge enabled words of the committing write into this block.
        always_comb begin
            blk_d = blk_q;
            if (wr_en && acc_addr == ADDR_W'(i))
                for (int j = 0; j < WORDS_PER_BLOCK; j++)
                    if (acc_be[j])
                        blk_d[WORD_W*j +: WORD_W] = acc_din[WORD_W*j +: WORD_W];
        end

        // Contents survive reset, so this register has no reset term.
        always_ff @(posedge clk) begin
            blk_q <= blk_d;
        end

        assign rd_blk[i] = blk_q;
    end

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench for wait_state_memory: a LATENCY=3 and a LATENCY=1 instance.
module tb_wait_state_memory;

    // Hand-computed block contents; these depend on the power-up pattern build.
`ifdef WAIT_STATE_MEMORY_INIT_PATTERN_EN
    localparam logic [31:0] EXP_B0  = 32'h03020100;
    localparam logic [31:0] EXP_B1  = 32'h07060504;
    localparam logic [31:0] EXP_B3  = 32'h0F0E0D0C;
    localparam logic [31:0] EXP_B4  = 32'h13121110;
    localparam logic [31:0] EXP_B5  = 32'h17161514;
    localparam logic [31:0] EXP_B2W = 32'h0BBB09DD;
    localparam logic [31:0] EXP_B63 = 32'hFFFEFDFC;
    localparam logic [31:0] EXP_A10 = 32'h5A2A2928;
`else
    localparam logic [31:0] EXP_B0  = 32'h00000000;
    localparam logic [31:0] EXP_B1  = 32'h00000000;
    localparam logic [31:0] EXP_B3  = 32'h00000000;
    localparam logic [31:0] EXP_B4  = 32'h00000000;
    localparam logic [31:0] EXP_B5  = 32'h00000000;
    localparam logic [31:0] EXP_B2W = 32'h00BB00DD;
    localparam logic [31:0] EXP_B63 = 32'h00000000;
    localparam logic [31:0] EXP_A10 = 32'h5A000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        u_request = 1'b0, u_we = 1'b0;
    logic [3:0]  u_be = '0;
    logic [5:0]  u_addr = '0;
    logic [31:0] u_din = '0;
    logic        u_busy, u_ready;
    logic [31:0] u_dout;

    logic        r1_request = 1'b0, r1_we = 1'b0;
    logic [3:0]  r1_be = '0;
    logic [5:0]  r1_addr = '0;
    logic [31:0] r1_din = '0;
    logic        r1_busy, r1_ready;
    logic [31:0] r1_dout;

    wait_state_memory #(.ADDR_W(6), .WORD_W(8), .WORDS_PER_BLOCK(4), .LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .u_request(u_request), .u_we(u_we), .u_be(u_be),
        .u_addr(u_addr), .u_din(u_din), .u_busy(u_busy), .u_ready(u_ready), .u_dout(u_dout));

    wait_state_memory #(.ADDR_W(6), .WORD_W(8), .WORDS_PER_BLOCK(4), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .u_request(r1_request), .u_we(r1_we), .u_be(r1_be),
        .u_addr(r1_addr), .u_din(r1_din), .u_busy(r1_busy), .u_ready(r1_ready), .u_dout(r1_dout));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with
    // inputs scrambled so a design using live inputs would misbehave.
    task automatic issue(input logic we, input logic [3:0] be, input logic [5:0] a,
                         input logic [31:0] d);
        u_request = 1'b1; u_we = we; u_be = be; u_addr = a; u_din = d;
        @(posedge clk);
        @(negedge clk);
        u_request = 1'b0; u_we = ~we; u_be = ~be; u_addr = ~a; u_din = ~d;
    endtask

    // Negedges waited (bounded) until u_ready is seen high.
    task automatic wait_ready(output int n);
        n = 0;
        while (!u_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        chk("rst_busy",  {31'd0, u_busy},  32'd0);
        chk("rst_ready", {31'd0, u_ready}, 32'd0);
        chk("rst_dout",  u_dout,           32'd0);
        chk("rst1_ready", {31'd0, r1_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read block 5 on the first edge after reset release.
        issue(1'b0, 4'h0, 6'd5, 32'h0);
        chk("rd5_busy_e0",  {31'd0, u_busy},  32'd1);
        chk("rd5_ready_e0", {31'd0, u_ready}, 32'd0);
        wait_ready(n);
        chk("rd5_latency", 32'(n), 32'd2);
        chk("rd5_busy_e2", {31'd0, u_busy}, 32'd1);
        chk("rd5_dout",    u_dout,          EXP_B5);
        @(negedge clk);
        chk("rd5_ready_e3", {31'd0, u_ready}, 32'd0);
        chk("rd5_busy_e3",  {31'd0, u_busy},  32'd0);

        // Partial write to block 2; dout must not move, then read it back.
        issue(1'b1, 4'b0101, 6'd2, 32'hAABBCCDD);
        wait_ready(n);
        chk("wr2_latency", 32'(n), 32'd2);
        chk("wr2_dout_hold", u_dout, EXP_B5);
        @(negedge clk);
        issue(1'b0, 4'h0, 6'd2, 32'h0);
        wait_ready(n);
        chk("rd2_dout", u_dout, EXP_B2W);
        @(negedge clk);

        // Write with no word enables leaves block 4 untouched.
        issue(1'b1, 4'h0, 6'd4, 32'hFFFFFFFF);
        wait_ready(n);
        @(negedge clk);
        issue(1'b0, 4'h0, 6'd4, 32'h0);
        wait_ready(n);
        chk("rd4_be0", u_dout, EXP_B4);
        @(negedge clk);

        // Full write to block 7 and read back.
        issue(1'b1, 4'hF, 6'd7, 32'hC0FFEE11);
        wait_ready(n);
        @(negedge clk);
        issue(1'b0, 4'h0, 6'd7, 32'h0);
        wait_ready(n);
        chk("rd7_full", u_dout, 32'hC0FFEE11);
        @(negedge clk);

        // Request held high: block 0 then block 1, pulses 4 cycles apart.
        u_request = 1'b1; u_we = 1'b0; u_be = 4'h0; u_addr = 6'd0;
        @(posedge clk);
        @(negedge clk);
        u_addr = 6'd1;
        wait_ready(n);
        chk("hold_first_lat", 32'(n), 32'd2);
        chk("hold_first_dout", u_dout, EXP_B0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_ready && n < 20);
        u_request = 1'b0;
        chk("hold_spacing", 32'(n), 32'd4);
        chk("hold_second_dout", u_dout, EXP_B1);
        @(negedge clk);
        @(negedge clk);
        chk("hold_idle_busy", {31'd0, u_busy}, 32'd0);

        // Reset in WAIT of a full write to block 3 aborts it.
        issue(1'b1, 4'hF, 6'd3, 32'hFFFFFFFF);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",  {31'd0, u_busy},  32'd0);
        chk("abort_ready", {31'd0, u_ready}, 32'd0);
        chk("abort_dout",  u_dout,           32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 4'h0, 6'd3, 32'h0);
        wait_ready(n);
        chk("abort_rd3_lat", 32'(n), 32'd2);
        chk("abort_rd3", u_dout, EXP_B3);
        @(negedge clk);

        // LATENCY=1 instance: completion the cycle after acceptance.
        r1_request = 1'b1; r1_we = 1'b0; r1_addr = 6'd63;
        @(posedge clk);
        @(negedge clk);
        r1_request = 1'b0; r1_addr = 6'd0;
        chk("l1_ready", {31'd0, r1_ready}, 32'd1);
        chk("l1_busy",  {31'd0, r1_busy},  32'd1);
        chk("l1_dout",  r1_dout,           EXP_B63);
        @(negedge clk);
        chk("l1_ready_low", {31'd0, r1_ready}, 32'd0);
        chk("l1_busy_low",  {31'd0, r1_busy},  32'd0);

        // LATENCY=1 write of the top word of block 10, then read back.
        r1_request = 1'b1; r1_we = 1'b1; r1_be = 4'b1000; r1_addr = 6'd10; r1_din = 32'h5A5A5A5A;
        @(posedge clk);
        @(negedge clk);
        r1_request = 1'b0; r1_din = 32'h0;
        chk("l1_wr_dout_hold", r1_dout, EXP_B63);
        @(negedge clk);
        r1_request = 1'b1; r1_we = 1'b0; r1_addr = 6'd10;
        @(posedge clk);
        @(negedge clk);
        r1_request = 1'b0;
        chk("l1_rd10", r1_dout, EXP_A10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
